// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full-subtractor slice: d = a - b - bin, with borrow-out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & bin) | (~a & b) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b computed LSB first through one fs_cell,
// with the borrow carried between slices in a flop. Results are held in
// output registers that only change on completion or reset.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  sub_state_t       state_r;
  sub_state_t       state_nxt_s;
  logic             accept_s;
  logic             last_s;

  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-2:0] d_sr_r;
  logic             bin_r;
  logic             amsb_r;
  logic             bmsb_r;

  logic             d_s;
  logic             bout_s;
  logic [WIDTH-1:0] d_cat_s;

  fs_cell u_cell (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .bin  (bin_r),
    .d    (d_s),
    .bout (bout_s)
  );

  // Difference bits collected so far with the current slice's bit on top;
  // on the last slice this is the complete result.
  assign d_cat_s = {d_s, d_sr_r};

  // Next-state decode plus operand-accept and last-slice strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DONE;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand shift registers, borrow chain, slice counter and sign latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_r <= {WIDTH{1'b0}};
      b_sr_r <= {WIDTH{1'b0}};
      d_sr_r <= {(WIDTH-1){1'b0}};
      bin_r  <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      amsb_r <= 1'b0;
      bmsb_r <= 1'b0;
    end else if (accept_s) begin
      a_sr_r <= a;
      b_sr_r <= b;
      d_sr_r <= {(WIDTH-1){1'b0}};
      bin_r  <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      amsb_r <= a[WIDTH-1];
      bmsb_r <= b[WIDTH-1];
    end else if (state_r == RUN) begin
      a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
      b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
      d_sr_r <= d_cat_s[WIDTH-1:1];
      bin_r  <= bout_s;
      // Hold on the last slice so the counter never passes WIDTH-1.
      cnt_r  <= last_s ? cnt_r : cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      a_sr_r <= a_sr_r;
      b_sr_r <= b_sr_r;
      d_sr_r <= d_sr_r;
      bin_r  <= bin_r;
      cnt_r  <= cnt_r;
    end
  end

  // Registered status flags and result registers updated on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= {WIDTH{1'b0}};
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      busy <= (state_nxt_s == RUN);
      done <= (state_nxt_s == DONE);
      if (last_s) begin
        diff   <= d_cat_s;
        borrow <= bout_s;
        ovf    <= (amsb_r != bmsb_r) & (d_s != amsb_r);
      end else begin
        diff   <= diff;
        borrow <= borrow;
        ovf    <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): an arithmetic
// reference model checked every cycle, plus directed literal checks.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_i = 8'h00;
  logic [W-1:0] b_i = 8'h00;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // cyc_left counts edges until the pending result lands; zero means the
  // unit can accept a start on the next edge.
  int           cyc_left = 0;
  logic [W-1:0] pend_diff = 8'h00;
  logic         pend_borrow = 1'b0;
  logic         pend_ovf = 1'b0;
  logic [W-1:0] exp_diff = 8'h00;
  logic         exp_borrow = 1'b0;
  logic         exp_ovf = 1'b0;
  logic         exp_done = 1'b0;
  logic         exp_busy = 1'b0;

  function automatic logic sub_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'($signed(x)) - int'($signed(y));
    return (r > 127) || (r < -128);
  endfunction

  // Model update at each edge from the driven inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_left   <= 0;
      exp_diff   <= 8'h00;
      exp_borrow <= 1'b0;
      exp_ovf    <= 1'b0;
      exp_done   <= 1'b0;
      exp_busy   <= 1'b0;
    end else if (cyc_left != 0) begin
      cyc_left <= cyc_left - 1;
      exp_busy <= (cyc_left > 1);
      exp_done <= (cyc_left == 1);
      if (cyc_left == 1) begin
        exp_diff   <= pend_diff;
        exp_borrow <= pend_borrow;
        exp_ovf    <= pend_ovf;
      end
    end else if (start) begin
      cyc_left    <= W;
      pend_diff   <= a_i - b_i;
      pend_borrow <= (a_i < b_i);
      pend_ovf    <= sub_ovf(a_i, b_i);
      exp_busy    <= 1'b1;
      exp_done    <= 1'b0;
    end else begin
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("busy",   {31'd0, busy},   {31'd0, exp_busy});
    check("done",   {31'd0, done},   {31'd0, exp_done});
    check("diff",   {24'd0, diff},   {24'd0, exp_diff});
    check("borrow", {31'd0, borrow}, {31'd0, exp_borrow});
    check("ovf",    {31'd0, ovf},    {31'd0, exp_ovf});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for done; returns negedge index n at which it was seen.
  task automatic wait_done(output int n_seen, output int busy_cnt);
    n_seen   = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        n_seen = n;
        break;
      end
    end
    check("done_seen", {31'd0, (n_seen != 0)}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int n_seen;
    int bcnt;
    a_i = av;
    b_i = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n_seen, bcnt);
    // First negedge after the accept edge is n=1, so edges = n-1.
    check("latency", n_seen - 1, 32'd8);
    check("busy_cycles", bcnt, 32'd8);
    check("lit_diff",   {24'd0, diff},   {24'd0, ed});
    check("lit_borrow", {31'd0, borrow}, {31'd0, eb});
    check("lit_ovf",    {31'd0, ovf},    {31'd0, eo});
  endtask

  initial begin
    int n1;
    int n2;
    int bc;
    int extra;

    // Reset state.
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    #2 rst = 1'b0;
    tick();

    // Basic operations.
    run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    tick();
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    tick();
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    tick();

    // Back-to-back with start held high through DONE.
    a_i = 8'h7F;
    b_i = 8'hFF;
    start = 1'b1;
    tick();
    wait_done(n1, bc);
    check("b2b1_diff",   {24'd0, diff},   32'h80);
    check("b2b1_borrow", {31'd0, borrow}, 32'd1);
    check("b2b1_ovf",    {31'd0, ovf},    32'd1);
    a_i = 8'h10;
    b_i = 8'h10;
    wait_done(n2, bc);
    start = 1'b0;
    check("b2b_gap", n2, 32'd9);
    check("b2b2_diff",   {24'd0, diff},   32'h00);
    check("b2b2_borrow", {31'd0, borrow}, 32'd0);
    check("b2b2_ovf",    {31'd0, ovf},    32'd0);
    tick();

    // Start pulsed during RUN with other operands: must be ignored.
    a_i = 8'h33;
    b_i = 8'h44;
    start = 1'b1;
    tick();
    start = 1'b0;
    n1 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 3) begin
        a_i = 8'h01;
        b_i = 8'h01;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n1 = n;
        break;
      end
    end
    check("ign_latency", n1 - 1, 32'd8);
    check("ign_diff",   {24'd0, diff},   32'hEF);
    check("ign_borrow", {31'd0, borrow}, 32'd1);
    check("ign_ovf",    {31'd0, ovf},    32'd0);
    extra = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ign_no_extra_done", extra, 32'd0);
    tick();

    // Reset 4 cycles into RUN aborts the operation.
    a_i = 8'hFF;
    b_i = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_borrow", {31'd0, borrow}, 32'd0);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    extra = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("abort_no_done", extra, 32'd0);
    tick();
    run_op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
